// File: rtl/bm_pkg.sv
// Shared bus-matrix definitions: HTRANS/HRESP/HBURST encodings, ctrl bundle layout.
// Latency: n/a (types, constants and one packing helper only).
// Backpressure: n/a.
package bm_pkg;

  localparam int ADDR_W_DEF = 32;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // HBURST encodings
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // ctrl bundle layout: {mastlock, prot[3:0], burst[2:0], size[2:0], write}
  localparam int CTRL_W         = 12;
  localparam int CTRL_WRITE_BIT = 0;
  localparam int CTRL_SIZE_LSB  = 1;
  localparam int CTRL_BURST_LSB = 4;
  localparam int CTRL_PROT_LSB  = 7;
  localparam int CTRL_LOCK_BIT  = 11;

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic       mastlock,
    input logic [3:0] prot,
    input logic [2:0] burst,
    input logic [2:0] size,
    input logic       write
  );
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_LOCK_BIT]                = mastlock;
    c[CTRL_PROT_LSB  +: 4]          = prot;
    c[CTRL_BURST_LSB +: 3]          = burst;
    c[CTRL_SIZE_LSB  +: 3]          = size;
    c[CTRL_WRITE_BIT]               = write;
    return c;
  endfunction

endpackage

// File: rtl/bm_input_hold_reg.sv
// Address/control hold register with output mux selecting held or live values.
// Latency: 0 cycles on the live path, 1 cycle to present a captured transfer.
// Backpressure: none here; the caller only asserts load when the register is free.
module bm_input_hold_reg
  import bm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              use_hold,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        trans_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        trans_out,
  output logic [CTRL_W-1:0] ctrl_out
);

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        trans_q, trans_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Capture the live address phase on load, otherwise keep the held copy.
  always_comb begin
    addr_d  = addr_q;
    trans_d = trans_q;
    ctrl_d  = ctrl_q;
    if (load) begin
      addr_d  = addr_in;
      trans_d = trans_in;
      ctrl_d  = ctrl_in;
    end
  end

  // Hold register storage; reset empties it to an IDLE, all-zero phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      trans_q <= HTRANS_IDLE;
      ctrl_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      trans_q <= trans_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Present the held phase while one is pending, otherwise bypass the live inputs.
  always_comb begin
    addr_out  = addr_in;
    trans_out = trans_in;
    ctrl_out  = ctrl_in;
    if (use_hold) begin
      addr_out  = addr_q;
      trans_out = trans_q;
      ctrl_out  = ctrl_q;
    end
  end

endmodule

// File: rtl/bm_input_stage.sv
// Bus-matrix input stage: requests arbitration, holds unaccepted address phases, relays data-phase ready/resp.
// Latency: 0-cycle bypass when accepted immediately; held phases stall the master with HREADYOUTS=0.
// Backpressure: active_trans=0 keeps the phase pending; BM_INPUT_REG_ALWAYS_EN registers every request.
module bm_input_stage
  import bm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        trans_out,
  output logic [11:0]       ctrl_out,
  output logic              held_tran_out,
  input  logic              active_trans,
  input  logic              readyout_in,
  input  logic [1:0]        resp_in
);

  logic              trans_req;
  logic              pend_q, pend_d;
  logic              dphase_q, dphase_d;
  logic              hold_load;
  logic              use_hold;
  logic [CTRL_W-1:0] ctrl_live;

  assign trans_req = HSELS & HTRANSS[1] & HREADYS;
  assign ctrl_live = pack_ctrl(HMASTLOCKS, HPROTS, HBURSTS, HSIZES, HWRITES);

`ifdef BM_INPUT_REG_ALWAYS_EN
  // Registered mode: every request goes through the hold register; an
  // acceptance only counts against a phase that is already being presented.
  always_comb begin
    pend_d    = pend_q;
    dphase_d  = dphase_q;
    hold_load = trans_req & (~pend_q | active_trans);
    use_hold  = 1'b1;
    if (trans_req)
      pend_d = 1'b1;
    else if (active_trans)
      pend_d = 1'b0;
    if (active_trans & pend_q)
      dphase_d = 1'b1;
    else if (readyout_in)
      dphase_d = 1'b0;
    sel_out = pend_q;
  end
`else
  // Bypass mode: an immediately accepted phase never touches the hold register.
  always_comb begin
    pend_d    = pend_q;
    dphase_d  = dphase_q;
    hold_load = trans_req & ~active_trans & ~pend_q;
    use_hold  = pend_q;
    if (active_trans)
      pend_d = 1'b0;
    else if (trans_req)
      pend_d = 1'b1;
    if (active_trans)
      dphase_d = 1'b1;
    else if (readyout_in)
      dphase_d = 1'b0;
    sel_out = pend_q | trans_req;
  end
`endif

  // Pending and data-phase flags.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q   <= 1'b0;
      dphase_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      dphase_q <= dphase_d;
    end
  end

  // Master-facing ready/response: stall while pending, else relay the data phase.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (pend_q)
      HREADYOUTS = 1'b0;
    else if (dphase_q)
      HREADYOUTS = readyout_in;
    if (dphase_q)
      HRESPS = resp_in;
  end

  assign held_tran_out = pend_q;

  bm_input_hold_reg #(.ADDR_W(ADDR_W)) u_hold (
    .clk       (HCLK),
    .rst       (HRESET),
    .load      (hold_load),
    .use_hold  (use_hold),
    .addr_in   (HADDRS),
    .trans_in  (HTRANSS),
    .ctrl_in   (ctrl_live),
    .addr_out  (addr_out),
    .trans_out (trans_out),
    .ctrl_out  (ctrl_out)
  );

endmodule

// File: tb/tb_bm_input_stage.sv
// Directed bench for bm_input_stage: vector table for bypass/hold sequences plus hand-written corner cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_bm_input_stage;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_out;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic [11:0] ctrl_out;
  logic        held_tran_out;
  logic        active_trans;
  logic        readyout_in;
  logic [1:0]  resp_in;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  bm_input_stage #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_out(sel_out), .addr_out(addr_out), .trans_out(trans_out), .ctrl_out(ctrl_out),
    .held_tran_out(held_tran_out), .active_trans(active_trans), .readyout_in(readyout_in),
    .resp_in(resp_in)
  );

  typedef struct {
    string       name;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        active;
    logic        rdy_in;
    logic [1:0]  resp;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic        e_sel;
    logic [31:0] e_addr;
    logic [1:0]  e_trans;
    logic        e_held;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hsel, input logic [1:0] htrans, input logic [31:0] haddr,
                       input logic active, input logic rdy_in, input logic [1:0] resp);
    HSELS        = hsel;
    HTRANSS      = htrans;
    HADDRS       = haddr;
    active_trans = active;
    readyout_in  = rdy_in;
    resp_in      = resp;
  endtask

  // Inputs are changed 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic to_sample();
    @(negedge HCLK);
  endtask

  task automatic to_drive();
    @(posedge HCLK);
    #1;
  endtask

  task automatic add(input string n, input logic hs, input logic [1:0] ht, input logic [31:0] ha,
                     input logic ac, input logic ri, input logic [1:0] rs,
                     input logic er, input logic [1:0] ep, input logic es, input logic [31:0] ea,
                     input logic [1:0] et, input logic eh);
    vec_t v;
    v.name = n; v.hsel = hs; v.htrans = ht; v.haddr = ha; v.active = ac; v.rdy_in = ri;
    v.resp = rs; v.e_rdy = er; v.e_resp = ep; v.e_sel = es; v.e_addr = ea; v.e_trans = et;
    v.e_held = eh;
    vecs.push_back(v);
  endtask

  initial begin
    HRESET = 1'b1; HWRITES = 1'b0; HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'h3;
    HMASTLOCKS = 1'b0; HREADYS = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_0040, 1'b0, 1'b1, 2'b00);

    // Reset state: stage empty, request follows trans_req combinationally.
    to_drive(); to_drive();
    to_sample();
    chk("rst_hreadyout", {31'd0, HREADYOUTS}, 32'd1);
    chk("rst_hresp", {30'd0, HRESPS}, 32'd0);
    chk("rst_held", {31'd0, held_tran_out}, 32'd0);
`ifndef BM_INPUT_REG_ALWAYS_EN
    chk("rst_sel_req", {31'd0, sel_out}, 32'd1);
`endif
    to_drive();
    HRESET = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 2'b00);
    to_drive();

`ifndef BM_INPUT_REG_ALWAYS_EN
    //   name          hsel ht     haddr          act  rdy  resp | rdy  resp  sel  addr           trans held
    add("idle",        1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 1'b0);
    add("bypass_acc",  1'b1, 2'b10, 32'h2000_0010, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 32'h2000_0010, 2'b10, 1'b0);
    add("dph_wait",    1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 1'b0);
    add("dph_done",    1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 1'b0);
    add("busy_noreq",  1'b1, 2'b01, 32'h0000_3000, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0000_3000, 2'b01, 1'b0);
    add("busy_nocap",  1'b0, 2'b00, 32'h0000_4000, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0000_4000, 2'b00, 1'b0);
    add("hold_req",    1'b1, 2'b10, 32'h0000_1000, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 32'h0000_1000, 2'b10, 1'b0);
    add("hold_c1",     1'b0, 2'b00, 32'h0000_5555, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_1000, 2'b10, 1'b1);
    add("hold_c2",     1'b1, 2'b11, 32'h0000_6666, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_1000, 2'b10, 1'b1);
    add("hold_acc",    1'b0, 2'b00, 32'h0000_7777, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_1000, 2'b10, 1'b1);
    add("hold_dph",    1'b0, 2'b00, 32'h0000_9999, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0000_9999, 2'b00, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].hsel, vecs[i].htrans, vecs[i].haddr, vecs[i].active, vecs[i].rdy_in, vecs[i].resp);
      to_sample();
      chk({vecs[i].name, "_rdy"},   {31'd0, HREADYOUTS},    {31'd0, vecs[i].e_rdy});
      chk({vecs[i].name, "_resp"},  {30'd0, HRESPS},        {30'd0, vecs[i].e_resp});
      chk({vecs[i].name, "_sel"},   {31'd0, sel_out},       {31'd0, vecs[i].e_sel});
      chk({vecs[i].name, "_addr"},  addr_out,               vecs[i].e_addr);
      chk({vecs[i].name, "_trans"}, {30'd0, trans_out},     {30'd0, vecs[i].e_trans});
      chk({vecs[i].name, "_held"},  {31'd0, held_tran_out}, {31'd0, vecs[i].e_held});
      to_drive();
    end

    // Two-cycle ERROR response relayed unchanged, then OKAY once the data phase ends.
    drive(1'b1, 2'b10, 32'h0000_2000, 1'b1, 1'b1, 2'b00);
    to_drive();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 2'b01);
    to_sample();
    chk("err1_resp", {30'd0, HRESPS}, 32'd1);
    chk("err1_rdy", {31'd0, HREADYOUTS}, 32'd0);
    to_drive();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 2'b01);
    to_sample();
    chk("err2_resp", {30'd0, HRESPS}, 32'd1);
    chk("err2_rdy", {31'd0, HREADYOUTS}, 32'd1);
    to_drive();
    to_sample();
    chk("err_after_resp", {30'd0, HRESPS}, 32'd0);
    to_drive();

    // Locked SEQ write held: held control comes from the register, not live inputs.
    HMASTLOCKS = 1'b1; HWRITES = 1'b1; HBURSTS = 3'b011; HSIZES = 3'b010; HPROTS = 4'h3;
    drive(1'b1, 2'b11, 32'h0000_ABC0, 1'b0, 1'b1, 2'b00);
    to_drive();
    HMASTLOCKS = 1'b0; HWRITES = 1'b0; HBURSTS = 3'b000;
    drive(1'b0, 2'b00, 32'h0000_1111, 1'b0, 1'b1, 2'b00);
    to_sample();
    chk("lock_ctrl", {20'd0, ctrl_out}, 32'h0000_09B5);
    chk("lock_trans_seq", {30'd0, trans_out}, 32'd3);
    chk("lock_addr", addr_out, 32'h0000_ABC0);
    chk("lock_held", {31'd0, held_tran_out}, 32'd1);
    to_drive();

    // Reset while pending discards the held phase.
    HRESET = 1'b1;
    to_drive();
    to_sample();
    chk("rstp_held", {31'd0, held_tran_out}, 32'd0);
    chk("rstp_rdy", {31'd0, HREADYOUTS}, 32'd1);
    chk("rstp_sel", {31'd0, sel_out}, 32'd0);
    chk("rstp_addr_live", addr_out, 32'h0000_1111);
    to_drive();
    HRESET = 1'b0;
    to_drive();
`else
    // Registered mode: a same-cycle acceptance is ignored and the phase is held.
    drive(1'b1, 2'b10, 32'h2000_0010, 1'b1, 1'b1, 2'b00);
    to_sample();
    chk("reg_sel0", {31'd0, sel_out}, 32'd0);
    chk("reg_rdy0", {31'd0, HREADYOUTS}, 32'd1);
    to_drive();
    drive(1'b0, 2'b00, 32'h0000_7777, 1'b0, 1'b1, 2'b00);
    to_sample();
    chk("reg_sel1", {31'd0, sel_out}, 32'd1);
    chk("reg_held1", {31'd0, held_tran_out}, 32'd1);
    chk("reg_wait", {31'd0, HREADYOUTS}, 32'd0);
    chk("reg_addr", addr_out, 32'h2000_0010);
    chk("reg_trans", {30'd0, trans_out}, 32'd2);
    to_drive();
    drive(1'b0, 2'b00, 32'h0000_7777, 1'b1, 1'b1, 2'b00);
    to_drive();
    drive(1'b0, 2'b00, 32'h0000_7777, 1'b0, 1'b1, 2'b00);
    to_sample();
    chk("reg_held_clr", {31'd0, held_tran_out}, 32'd0);
    chk("reg_rdy_dph", {31'd0, HREADYOUTS}, 32'd1);
    chk("reg_sel_clr", {31'd0, sel_out}, 32'd0);
    to_drive();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bm_input_stage.md
BM_INPUT_STAGE -- requirements
Module: bm_input_stage

Interface
REQ-001 ADDR_W, 32, address width of HADDRS/addr_out.
REQ-002 HCLK  in  1  bus-matrix clock; all state updates on rising edge.
REQ-003 HRESET  in  1  reset, synchronous, active-high.
REQ-004 HSELS  in  1  slave select from master-side decoder.
REQ-005 HADDRS  in  ADDR_W  address.
REQ-006 HTRANSS  in  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-007 HWRITES  in  1  write.
REQ-008 HSIZES  in  3  size.
REQ-009 HBURSTS  in  3  burst type.
REQ-010 HPROTS  in  4  protection.
REQ-011 HMASTLOCKS  in  1  locked transfer.
REQ-012 HREADYS  in  1  bus ready; address phase valid only when high.
REQ-013 HREADYOUTS  out  1  ready to master.
REQ-014 HRESPS  out  2  response to master (OKAY 00, ERROR 01).
REQ-015 sel_out  out  1  request to output stages / arbiters (feeds req_portN).
REQ-016 addr_out  out  ADDR_W  live or held address.
REQ-017 trans_out  out  2  live or held HTRANS.
REQ-018 ctrl_out  out  12  {mastlock, prot[3:0], burst[2:0], size[2:0], write}, live or held.
REQ-019 held_tran_out  out  1  hold register occupied.
REQ-020 active_trans  in  1  output stage accepts this port's address phase this cycle.
REQ-021 readyout_in  in  1  data-phase ready from owning output stage.
REQ-022 resp_in  in  2  data-phase response from owning output stage.

Function
REQ-023 trans_req SHALL = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ only; IDLE/BUSY never request).
REQ-024 pend_reg SHALL set, capturing all address/control, on trans_req & ~active_trans; clear on active_trans; hold otherwise.
REQ-025 Hold register SHALL load only when pend_reg=0; live inputs ignored while pend_reg=1.
REQ-026 addr_out/trans_out/ctrl_out SHALL come from hold register when pend_reg=1, else from live inputs (zero-latency bypass).
REQ-027 sel_out SHALL = pend_reg | trans_req; held_tran_out SHALL = pend_reg.
REQ-028 dphase_reg SHALL set on active_trans; clear when readyout_in=1 and no new active_trans.
REQ-029 HREADYOUTS SHALL = 0 if pend_reg, else readyout_in if dphase_reg, else 1.
REQ-030 HRESPS SHALL = resp_in if dphase_reg, else OKAY; two-cycle ERROR passes through unchanged.
REQ-031 active_trans and trans_req in same cycle, pend_reg=0: no capture, dphase_reg set next cycle.
REQ-032 Pending transfer SHALL never be dropped or reordered; held SEQ forwarded as SEQ (burst re-marking is output-stage duty).
REQ-033 Master holding HMASTLOCKS while pending SHALL see mastlock in ctrl_out from the hold register.

Reset
REQ-034 HRESET=1 at an edge SHALL clear pend_reg, dphase_reg and hold register regardless of activity.
REQ-035 During/after reset: HREADYOUTS=1, HRESPS=OKAY, held_tran_out=0, sel_out=trans_req.

Configuration
REQ-036 BM_INPUT_REG_ALWAYS_EN defined: bypass removed; every trans_req captured (active_trans same cycle ignored), outputs only from hold register, sel_out=pend_reg, HREADYOUTS low cycle after each request; undefined: REQ-026/027/031 apply.

Structure
REQ-037 Shared package bm_pkg SHALL hold HTRANS/HRESP/HBURST encodings, ctrl_out field offsets, ADDR_W default.
REQ-038 Hold register plus output mux SHALL be sub-module bm_input_hold_reg; pend/dphase control stays in top.

Verification
REQ-039 NONSEQ 0x2000_0010, active_trans=1 same cycle -> no capture, HREADYOUTS=1, addr_out=0x2000_0010, dphase next cycle.
REQ-040 NONSEQ 0x1000, active_trans=0 for 3 cycles, then 1 -> held_tran_out=1 three cycles, HREADYOUTS=0, addr_out stays 0x1000 though HADDRS changes.
REQ-041 Data phase with resp_in=ERROR two cycles, readyout_in 0 then 1 -> HRESPS=01 both cycles, HREADYOUTS 0 then 1.
REQ-042 HRESET asserted while pend_reg=1 -> next cycle held_tran_out=0, HREADYOUTS=1, sel_out=0 with HSELS=0.
REQ-043 HTRANSS=BUSY, HSELS=1, HREADYS=1 -> sel_out=0, no capture.
REQ-044 BM_INPUT_REG_ALWAYS_EN defined, single NONSEQ with active_trans=1 -> captured, sel_out=1 next cycle, one wait state.
